// File: rtl/freq_meter_pkg.sv
// Shared types and elaboration helpers for freq_meter.
// Optional saturation build is selected with FREQ_METER_SAT_EN.
package freq_meter_pkg;

   localparam logic ST_IDLE = 1'b0;
   localparam logic ST_GATE = 1'b1;

   function automatic int unsigned gate_ticks(input int unsigned f_in, input int unsigned gate_hz);
      return f_in / gate_hz;
   endfunction

   function automatic int unsigned cw(input int unsigned n);
      return ($clog2(n) < 1) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/freq_meter_sync_edge_det.sv
// Synchronizes an asynchronous input and emits a one-cycle pulse on each rising edge.
module sync_edge_det #(
   parameter int unsigned SYNC_STAGES = 2
) (
   input  logic clk,
   input  logic rst_n,
   input  logic sig_i,
   output logic rise_o
);

   logic [SYNC_STAGES-1:0] sync_q;
   logic                   prev_q;

   if (SYNC_STAGES < 2) begin : g_bad_stages
      $error("sync_edge_det: SYNC_STAGES must be >= 2");
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync_q <= '0;
         prev_q <= 1'b0;
      end else begin
         sync_q <= {sync_q[SYNC_STAGES-2:0], sig_i};
         prev_q <= sync_q[SYNC_STAGES-1];
      end
   end

   assign rise_o = sync_q[SYNC_STAGES-1] & ~prev_q;

endmodule

// File: rtl/freq_meter.sv
// Gated frequency counter: rising edges of sig_in per GATE_TICKS-cycle window.
// FREQ_METER_SAT_EN: saturating edge counter plus ovf output; otherwise counter wraps.
module freq_meter
   import freq_meter_pkg::*;
#(
   parameter int unsigned F_IN        = 50_000_000,
   parameter int unsigned GATE_HZ     = 10,
   parameter int unsigned CNT_W       = 24,
   parameter int unsigned SYNC_STAGES = 2
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             sig_in,
   input  logic             enable,
   output logic [CNT_W-1:0] meas_out,
   output logic             meas_valid,
   output logic             busy
`ifdef FREQ_METER_SAT_EN
   ,
   output logic             ovf
`endif
);

   localparam int unsigned GATE_TICKS = gate_ticks(F_IN, GATE_HZ);
   localparam int unsigned GW         = cw(GATE_TICKS);
   localparam logic [GW-1:0] LAST     = GW'(GATE_TICKS - 1);

   if (GATE_TICKS < 2) begin : g_bad_gate
      $error("freq_meter: GATE_TICKS must be >= 2");
   end

   logic             rise;
   logic             state_q, state_d;
   logic [GW-1:0]    gate_cnt_q, gate_cnt_d;
   logic [CNT_W-1:0] edge_cnt_q, edge_cnt_d;
   logic [CNT_W-1:0] meas_q, meas_d;
   logic             valid_q, valid_d;
   logic [CNT_W-1:0] edge_next;

   sync_edge_det #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
      .clk    (clk),
      .rst_n  (rst_n),
      .sig_i  (sig_in),
      .rise_o (rise)
   );

`ifdef FREQ_METER_SAT_EN
   logic             sat_q, sat_d;
   logic             ovf_q, ovf_d;
   logic [CNT_W:0]   edge_sum;
   logic             sat_hit;

   assign edge_sum  = {1'b0, edge_cnt_q} + {{CNT_W{1'b0}}, rise};
   assign sat_hit   = edge_sum[CNT_W];
   assign edge_next = sat_hit ? '1 : edge_sum[CNT_W-1:0];
`else
   assign edge_next = edge_cnt_q + {{(CNT_W-1){1'b0}}, rise};
`endif

   always_comb begin
      state_d    = state_q;
      gate_cnt_d = '0;
      edge_cnt_d = '0;
      meas_d     = meas_q;
      valid_d    = 1'b0;
`ifdef FREQ_METER_SAT_EN
      sat_d      = 1'b0;
      ovf_d      = ovf_q;
`endif
      if (state_q == ST_IDLE) begin
         if (enable) state_d = ST_GATE;
      end else if (gate_cnt_q == LAST) begin
         // Last gate cycle: the edge seen this cycle still belongs to this window.
         meas_d  = edge_next;
         valid_d = 1'b1;
`ifdef FREQ_METER_SAT_EN
         ovf_d   = sat_q | sat_hit;
`endif
         state_d = enable ? ST_GATE : ST_IDLE;
      end else if (!enable) begin
         state_d = ST_IDLE;
      end else begin
         gate_cnt_d = gate_cnt_q + 1'b1;
         edge_cnt_d = edge_next;
`ifdef FREQ_METER_SAT_EN
         sat_d      = sat_q | sat_hit;
`endif
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= ST_IDLE;
         gate_cnt_q <= '0;
         edge_cnt_q <= '0;
         meas_q     <= '0;
         valid_q    <= 1'b0;
`ifdef FREQ_METER_SAT_EN
         sat_q      <= 1'b0;
         ovf_q      <= 1'b0;
`endif
      end else begin
         state_q    <= state_d;
         gate_cnt_q <= gate_cnt_d;
         edge_cnt_q <= edge_cnt_d;
         meas_q     <= meas_d;
         valid_q    <= valid_d;
`ifdef FREQ_METER_SAT_EN
         sat_q      <= sat_d;
         ovf_q      <= ovf_d;
`endif
      end
   end

   assign meas_out   = meas_q;
   assign meas_valid = valid_q;
   assign busy       = (state_q == ST_GATE);
`ifdef FREQ_METER_SAT_EN
   assign ovf        = ovf_q;
`endif

endmodule

// File: tb/tb_freq_meter.sv
// Scoreboard bench for freq_meter: an 8-bit and a 4-bit instance share stimulus,
// expected windows are queued at stimulus time and popped by per-instance monitors.
module tb_freq_meter;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic sig_in = 1'b0;
   logic enable = 1'b0;
   logic [7:0] meas_out8;
   logic [3:0] meas_out4;
   logic valid8, valid4, busy8, busy4;
`ifdef FREQ_METER_SAT_EN
   logic ovf8, ovf4;
`endif

   int unsigned cyc = 0;
   int unsigned period = 0;
   logic manual = 1'b0;
   int n_cmp = 0;
   int n_bad = 0;

   typedef struct {
      int unsigned cyc;
      int unsigned val;
      logic        ovf;
   } exp_t;

   exp_t q8[$];
   exp_t q4[$];

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   freq_meter #(.F_IN(1000), .GATE_HZ(10), .CNT_W(8), .SYNC_STAGES(2)) u_dut8 (
      .clk(clk), .rst_n(rst_n), .sig_in(sig_in), .enable(enable),
      .meas_out(meas_out8), .meas_valid(valid8), .busy(busy8)
`ifdef FREQ_METER_SAT_EN
      , .ovf(ovf8)
`endif
   );

   freq_meter #(.F_IN(1000), .GATE_HZ(10), .CNT_W(4), .SYNC_STAGES(2)) u_dut4 (
      .clk(clk), .rst_n(rst_n), .sig_in(sig_in), .enable(enable),
      .meas_out(meas_out4), .meas_valid(valid4), .busy(busy4)
`ifdef FREQ_METER_SAT_EN
      , .ovf(ovf4)
`endif
   );

   task automatic chk(input string nm, input int unsigned act, input int unsigned exp);
      n_cmp++;
      if (act != exp) begin
         n_bad++;
         $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
      end
   endtask

   // Reference results for n edges in one window, per counter width.
   function automatic int unsigned m8(input int unsigned n);
      return n % 256;
   endfunction

   function automatic int unsigned m4(input int unsigned n);
`ifdef FREQ_METER_SAT_EN
      return (n > 15) ? 15 : n;
`else
      return n % 16;
`endif
   endfunction

   task automatic exp_win(input int unsigned at, input int unsigned n);
      exp_t e;
      e.cyc = at; e.val = m8(n); e.ovf = 1'b0;
      q8.push_back(e);
      e.val = m4(n); e.ovf = (n > 15);
      q4.push_back(e);
   endtask

   task automatic wait_cyc(input int unsigned c);
      while (cyc < c) @(negedge clk);
   endtask

   // sig_in source: periodic when period != 0, else follows manual.
   initial begin
      int unsigned ph;
      ph = 0;
      forever begin
         @(posedge clk);
         #2;
         if (period == 0) begin
            sig_in = manual;
         end else begin
            ph = (ph + 1 >= period) ? 0 : ph + 1;
            sig_in = (ph < period / 2);
         end
      end
   end

   always @(negedge clk) begin
      if (valid8) begin
         if (q8.size() == 0) chk("unexpected_valid8", 1, 0);
         else begin
            exp_t e;
            e = q8.pop_front();
            chk("meas8", meas_out8, e.val);
            chk("valid8_cycle", cyc, e.cyc);
`ifdef FREQ_METER_SAT_EN
            chk("ovf8", ovf8, e.ovf);
`endif
         end
      end
   end

   always @(negedge clk) begin
      if (valid4) begin
         if (q4.size() == 0) chk("unexpected_valid4", 1, 0);
         else begin
            exp_t e;
            e = q4.pop_front();
            chk("meas4", meas_out4, e.val);
            chk("valid4_cycle", cyc, e.cyc);
`ifdef FREQ_METER_SAT_EN
            chk("ovf4", ovf4, e.ovf);
`endif
         end
      end
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int unsigned m;
      int unsigned drops;

      // Reset held while the input toggles
      period = 2;
      repeat (10) @(negedge clk);
      chk("rst_meas8", meas_out8, 0);
      chk("rst_meas4", meas_out4, 0);
      chk("rst_valid8", valid8, 0);
      chk("rst_valid4", valid4, 0);
      chk("rst_busy8", busy8, 0);
      chk("rst_busy4", busy4, 0);
`ifdef FREQ_METER_SAT_EN
      chk("rst_ovf8", ovf8, 0);
      chk("rst_ovf4", ovf4, 0);
`endif
      period = 0;
      repeat (5) @(negedge clk);
      rst_n = 1'b1;
      repeat (3) @(negedge clk);

      // Three back-to-back windows at period 10
      period = 10;
      repeat (20) @(negedge clk);
      m = cyc;
      enable = 1'b1;
      exp_win(m + 101, 10);
      exp_win(m + 201, 10);
      exp_win(m + 301, 10);
      drops = 0;
      wait_cyc(m + 1);
      while (cyc < m + 300) begin
         if (!busy8) drops++;
         @(negedge clk);
      end
      enable = 1'b0;
      chk("busy_drops", drops, 0);
      wait_cyc(m + 305);
      chk("busy_after_stop", busy8, 0);

      // Maximum input rate
      period = 2;
      repeat (20) @(negedge clk);
      m = cyc;
      enable = 1'b1;
      exp_win(m + 101, 50);
      wait_cyc(m + 100);
      enable = 1'b0;
      wait_cyc(m + 110);

      // Abort at gate cycle 40, then immediate re-enable
      period = 10;
      repeat (20) @(negedge clk);
      m = cyc;
      enable = 1'b1;
      wait_cyc(m + 40);
      enable = 1'b0;
      @(negedge clk);
      chk("abort_busy", busy8, 0);
      chk("abort_keep8", meas_out8, m8(50));
      chk("abort_keep4", meas_out4, m4(50));
      m = cyc;
      enable = 1'b1;
      exp_win(m + 101, 10);
      wait_cyc(m + 100);
      enable = 1'b0;
      wait_cyc(m + 110);

      // 20 edges per window, then back to 10
      period = 5;
      repeat (20) @(negedge clk);
      m = cyc;
      enable = 1'b1;
      exp_win(m + 101, 20);
      wait_cyc(m + 100);
      enable = 1'b0;
      period = 10;
      wait_cyc(m + 130);
      m = cyc;
      enable = 1'b1;
      exp_win(m + 101, 10);
      wait_cyc(m + 100);
      enable = 1'b0;
      wait_cyc(m + 110);

      // Single edges on the last gate cycle and the first cycle of the next window
      period = 0;
      manual = 1'b0;
      repeat (20) @(negedge clk);
      m = cyc;
      enable = 1'b1;
      exp_win(m + 101, 1);
      exp_win(m + 201, 0);
      exp_win(m + 301, 1);
      wait_cyc(m + 97);
      manual = 1'b1;
      wait_cyc(m + 99);
      manual = 1'b0;
      wait_cyc(m + 198);
      manual = 1'b1;
      wait_cyc(m + 200);
      manual = 1'b0;
      wait_cyc(m + 300);
      enable = 1'b0;
      wait_cyc(m + 310);

      // Asynchronous reset mid-window
      m = cyc;
      enable = 1'b1;
      wait_cyc(m + 50);
      rst_n = 1'b0;
      #1;
      chk("arst_meas8", meas_out8, 0);
      chk("arst_meas4", meas_out4, 0);
      chk("arst_valid8", valid8, 0);
      chk("arst_busy8", busy8, 0);
      chk("arst_busy4", busy4, 0);
`ifdef FREQ_METER_SAT_EN
      chk("arst_ovf4", ovf4, 0);
`endif
      enable = 1'b0;
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      repeat (150) @(negedge clk);
      chk("pending8", q8.size(), 0);
      chk("pending4", q4.size(), 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
